// File: rtl/peach_pkg.sv
// Shared Peach core definitions: funct3 codes, opcodes and LSU state encoding.
// Imported by the LSU, its alignment helper and the decoder.
package peach_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_ACCESS,
    LSU_WAIT,
    LSU_RESP
  } lsu_state_e;

endpackage

// File: rtl/peach_lsu_align.sv
// Combinational size/alignment logic: fault check, byte enables,
// lane-replicated store data and sign/zero-extended load extraction.
module peach_lsu_align
  import peach_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic        o_fault,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [3:0]  w_be_b;
  logic [3:0]  w_be_h;

  always_comb begin
    w_byte = i_rdata[7:0];
    unique case (i_addr)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
    endcase
  end

  assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
  assign w_be_b = 4'b0001 << i_addr;
  assign w_be_h = i_addr[1] ? 4'b1100 : 4'b0011;

  // Unsigned codes are load-only, so a store with them faults.
  always_comb begin
    o_fault = 1'b0;
    o_be    = 4'b0000;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    unique case (i_funct3)
      F3_B: begin
        o_be    = w_be_b;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{w_byte[7]}}, w_byte};
      end
      F3_H: begin
        o_fault = i_addr[0];
        o_be    = w_be_h;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{w_half[15]}}, w_half};
      end
      F3_W: begin
        o_fault = |i_addr;
        o_be    = 4'b1111;
      end
      F3_BU: begin
        o_fault = i_we;
        o_be    = w_be_b;
        o_rdata = {24'h0, w_byte};
      end
      F3_HU: begin
        o_fault = i_we | i_addr[0];
        o_be    = w_be_h;
        o_rdata = {16'h0, w_half};
      end
      default: o_fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/peach_lsu.sv
// Peach RV32I load/store unit: request FSM, memory strobes, response regs.
// Optional output port register enabled by `define PEACH_LSU_MMIO_EN.
module peach_lsu
  import peach_pkg::*;
#(
  parameter logic [31:0] MMIO_ADDR = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [7:0]  out
);

`ifdef PEACH_LSU_MMIO_EN
  localparam logic MMIO_EN = 1'b1;
`else
  localparam logic MMIO_EN = 1'b0;
`endif

  lsu_state_e  r_state;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_resp_fault;
  logic [31:0] r_rdata;
  logic [7:0]  r_out;

  logic        w_idle;
  logic        w_acc;
  logic        w_mmio;
  logic        w_we;
  logic [2:0]  w_f3;
  logic [31:0] w_addr;
  logic [31:0] w_wd;
  logic [31:0] w_src;
  logic        w_fault;
  logic [3:0]  w_be;
  logic [31:0] w_mwdata;
  logic [31:0] w_ext;

  assign w_idle = (r_state == LSU_IDLE);
  assign w_acc  = (r_state == LSU_ACCESS);
  assign w_mmio = MMIO_EN && (r_addr[31:2] == MMIO_ADDR[31:2]);

  // Fault is judged on the live request in IDLE, on the latched one after.
  assign w_we   = w_idle ? req_we     : r_we;
  assign w_f3   = w_idle ? req_funct3 : r_f3;
  assign w_addr = w_idle ? req_addr   : r_addr;
  assign w_wd   = w_idle ? req_wdata  : r_wdata;
  assign w_src  = w_mmio ? {24'h0, r_out} : mem_rdata;

  peach_lsu_align u_align (
    .i_we     (w_we),
    .i_funct3 (w_f3),
    .i_addr   (w_addr[1:0]),
    .i_wdata  (w_wd),
    .i_rdata  (w_src),
    .o_fault  (w_fault),
    .o_be     (w_be),
    .o_wdata  (w_mwdata),
    .o_rdata  (w_ext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= LSU_IDLE;
      r_we         <= 1'b0;
      r_f3         <= 3'b000;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_resp_fault <= 1'b0;
      r_rdata      <= 32'h0;
      r_out        <= 8'h00;
    end else begin
      unique case (r_state)
        LSU_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_f3    <= req_funct3;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            if (w_fault) begin
              r_resp_fault <= 1'b1;
              r_rdata      <= 32'h0;
              r_state      <= LSU_RESP;
            end else begin
              r_state <= LSU_ACCESS;
            end
          end
        end
        LSU_ACCESS: begin
          if (r_we) begin
            if (w_mmio && w_be[0]) r_out <= w_mwdata[7:0];
            r_resp_fault <= 1'b0;
            r_rdata      <= 32'h0;
            r_state      <= LSU_RESP;
          end else begin
            r_state <= LSU_WAIT;
          end
        end
        LSU_WAIT: begin
          r_resp_fault <= 1'b0;
          r_rdata      <= w_ext;
          r_state      <= LSU_RESP;
        end
        LSU_RESP: r_state <= LSU_IDLE;
      endcase
    end
  end

  assign req_ready  = w_idle;
  assign resp_valid = (r_state == LSU_RESP);
  assign resp_fault = r_resp_fault;
  assign resp_rdata = r_rdata;

  assign mem_en    = w_acc & ~reset & ~w_mmio;
  assign mem_we    = mem_en & r_we;
  assign mem_be    = w_acc ? w_be : 4'b0000;
  assign mem_addr  = r_addr[31:2];
  assign mem_wdata = w_mwdata;

`ifdef PEACH_LSU_MMIO_EN
  assign out = r_out;
`else
  assign out = 8'h00;
`endif

endmodule

// File: tb/tb_peach_lsu.sv
// Directed self-checking bench for peach_lsu with a small word memory model.
// MMIO expectations follow the PEACH_LSU_MMIO_EN build setting.
module tb_peach_lsu;
  import peach_pkg::*;

`ifdef PEACH_LSU_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [7:0]  out;

  int checks = 0;
  int errors = 0;

  logic [3:0]  last_be;
  logic [31:0] last_wd;

  logic [31:0] mem [16];

  always #5 clk = ~clk;

  peach_lsu dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .out        (out)
  );

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem_rdata <= 32'h0;
    end else if (mem_en) begin
      if (mem_we)
        for (int i = 0; i < 4; i++)
          if (mem_be[i]) mem[mem_addr[3:0]][8*i +: 8] <= mem_wdata[8*i +: 8];
      mem_rdata <= mem[mem_addr[3:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic we,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_flt, input logic exp_mem);
    int lat;
    int en_cnt;
    int en_cyc;
    int exp_lat;
    logic we_s;
    logic [29:0] ad_s;
    @(negedge clk);
    check({tag, " ready"}, {31'h0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    en_cnt = 0;
    en_cyc = 0;
    we_s = 1'b0;
    ad_s = '0;
    for (int c = 1; c <= 6 && lat == 0; c++) begin
      @(negedge clk);
      if (mem_en) begin
        en_cnt++;
        en_cyc  = c;
        we_s    = mem_we;
        ad_s    = mem_addr;
        last_be = mem_be;
        last_wd = mem_wdata;
      end
      if (resp_valid) lat = c;
    end
    exp_lat = exp_flt ? 1 : (we ? 2 : 3);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " rdata"}, resp_rdata, exp_rd);
    check({tag, " fault"}, {31'h0, resp_fault}, {31'h0, exp_flt});
    check({tag, " mem_en cnt"}, en_cnt, (!exp_flt && exp_mem) ? 1 : 0);
    if (en_cnt != 0) begin
      check({tag, " mem_en cyc"}, en_cyc, 1);
      check({tag, " mem_we"}, {31'h0, we_s}, {31'h0, we});
      check({tag, " mem_addr"}, {2'b0, ad_s}, {2'b0, a[31:2]});
    end
  endtask

  initial begin
    last_be = '0;
    last_wd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst ready", {31'h0, req_ready}, 32'h1);
    check("rst resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst resp_fault", {31'h0, resp_fault}, 32'h0);
    check("rst mem_en", {31'h0, mem_en}, 32'h0);
    check("rst mem_we", {31'h0, mem_we}, 32'h0);
    check("rst mem_be", {28'h0, mem_be}, 32'h0);
    check("rst rdata", resp_rdata, 32'h0);
    check("rst out", {24'h0, out}, 32'h0);

    do_req("sw10", 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    check("sw10 be", {28'h0, last_be}, 32'hF);
    check("sw10 wdata", last_wd, 32'hDEADBEEF);
    do_req("lw10", 1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    @(negedge clk);
    check("lw10 hold", resp_rdata, 32'hDEADBEEF);
    check("lw10 pulse", {31'h0, resp_valid}, 32'h0);

    do_req("sw10b", 1'b1, F3_W, 32'h10, 32'h80FF1234, 32'h0, 1'b0, 1'b1);
    do_req("lb13", 1'b0, F3_B, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 1'b1);
    do_req("lbu13", 1'b0, F3_BU, 32'h13, 32'h0, 32'h00000080, 1'b0, 1'b1);
    do_req("lhu12", 1'b0, F3_HU, 32'h12, 32'h0, 32'h000080FF, 1'b0, 1'b1);
    do_req("lh10", 1'b0, F3_H, 32'h10, 32'h0, 32'h00001234, 1'b0, 1'b1);
    do_req("lb12", 1'b0, F3_B, 32'h12, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b1);

    do_req("sh06", 1'b1, F3_H, 32'h06, 32'h0000ABCD, 32'h0, 1'b0, 1'b1);
    check("sh06 be", {28'h0, last_be}, 32'hC);
    check("sh06 wdata", last_wd, 32'hABCDABCD);
    do_req("sb05", 1'b1, F3_B, 32'h05, 32'h00000011, 32'h0, 1'b0, 1'b1);
    check("sb05 be", {28'h0, last_be}, 32'h2);
    check("sb05 wdata", last_wd, 32'h11111111);
    do_req("lw04", 1'b0, F3_W, 32'h04, 32'h0, 32'hABCD1100, 1'b0, 1'b1);
    do_req("lh06", 1'b0, F3_H, 32'h06, 32'h0, 32'hFFFFABCD, 1'b0, 1'b1);
    do_req("lbu05", 1'b0, F3_BU, 32'h05, 32'h0, 32'h00000011, 1'b0, 1'b1);

    do_req("lw02 flt", 1'b0, F3_W, 32'h02, 32'h0, 32'h0, 1'b1, 1'b1);
    do_req("ld f3=3", 1'b0, 3'd3, 32'h00, 32'h0, 32'h0, 1'b1, 1'b1);
    do_req("ld f3=6", 1'b0, 3'd6, 32'h00, 32'h0, 32'h0, 1'b1, 1'b1);
    do_req("st f3=4", 1'b1, 3'd4, 32'h00, 32'h0, 32'h0, 1'b1, 1'b1);
    do_req("sh01 flt", 1'b1, F3_H, 32'h01, 32'h0, 32'h0, 1'b1, 1'b1);
    do_req("lhu03 flt", 1'b0, F3_HU, 32'h03, 32'h0, 32'h0, 1'b1, 1'b1);

    // Store interrupted by reset while in ACCESS must not write.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_W;
    req_addr   = 32'h08;
    req_wdata  = 32'h12345678;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rstacc mem_en pre", {31'h0, mem_en}, 32'h1);
    reset = 1'b1;
    #1;
    check("rstacc mem_we", {31'h0, mem_we}, 32'h0);
    check("rstacc mem_en", {31'h0, mem_en}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rstacc ready", {31'h0, req_ready}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      check("rstacc no resp", {31'h0, resp_valid}, 32'h0);
      @(negedge clk);
    end
    do_req("lw08", 1'b0, F3_W, 32'h08, 32'h0, 32'h0, 1'b0, 1'b1);

    do_req("mmio sb", 1'b1, F3_B, 32'hFFFFFF00, 32'h0000005A, 32'h0,
           1'b0, !MMIO);
    check("mmio out", {24'h0, out}, MMIO ? 32'h5A : 32'h0);
    do_req("mmio lbu", 1'b0, F3_BU, 32'hFFFFFF00, 32'h0, 32'h5A,
           1'b0, !MMIO);
    do_req("mmio sh", 1'b1, F3_H, 32'hFFFFFF02, 32'h00007777, 32'h0,
           1'b0, !MMIO);
    check("mmio out hold", {24'h0, out}, MMIO ? 32'h5A : 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/peach_lsu.md
# peach_lsu

Load/store unit for the Peach RV32I multi-cycle core. It sits between the core's memory states and a word-wide synchronous data memory. It accepts one load or store per request, checks alignment, generates byte enables and lane-replicated write data, and returns sign- or zero-extended load data. It answers each request with a single-cycle completion pulse, which the core's wait states poll.

## Interface
- Parameter `MMIO_ADDR`, default 32'hFFFF_FF00: word address of the output-port register (used only when MMIO is compiled in).
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; a request is accepted when `req_valid & req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data from rs2.
- `resp_valid` out 1: one-cycle completion pulse; there is no backpressure.
- `resp_rdata` out 32: extended load data, valid with `resp_valid`.
- `resp_fault` out 1: misaligned access or illegal funct3, valid with `resp_valid`.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write.
- `mem_be` out 4: byte enables; bit i corresponds to bits [8i+7:8i].
- `mem_addr` out 30: word address, equal to `req_addr[31:2]`.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rdata` in 32: read data, valid one cycle after the `mem_en` cycle.
- `out` out 8: output-port register.

## Operation
- States: IDLE, ACCESS, WAIT, RESP. The request is latched on accept.
- IDLE → RESP on accept with fault. No memory access is made for a faulting request.
- IDLE → ACCESS on accept without fault.
- ACCESS drives `mem_en`, plus `mem_we` for stores. A store goes to RESP; a load goes to WAIT.
- WAIT captures `mem_rdata`, performs lane extraction, and goes to RESP.
- RESP asserts `resp_valid` for one cycle and returns to IDLE.
- Fault conditions:
  - LH/LHU/SH with `addr[0]` = 1.
  - LW/SW with `addr[1:0]` ≠ 0.
  - Load funct3 of 3, 6 or 7.
  - Store funct3 ≥ 3.
- Store byte enables and write data:
  - SB: `be = 1 << addr[1:0]`, `wdata = {4{wdata[7:0]}}`.
  - SH: `be = addr[1] ? 4'b1100 : 4'b0011`, `wdata = {2{wdata[15:0]}}`.
  - SW: `be = 4'b1111`.
- Load extraction:
  - LB/LBU select byte lane `addr[1:0]`; LH/LHU select halfword lane `addr[1]`.
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.
  - LW passes the word through.
- `resp_rdata` is 0 for stores and for faults.
- Outside ACCESS, `mem_en`, `mem_we` and `mem_be` are 0.
- `mem_en` and `mem_we` are gated with `!reset`. A reset asserted during ACCESS performs no write.
- Reset mid-operation: the state returns to IDLE, the pending request is dropped, and no `resp_valid` is produced for it.
- `req_valid` seen outside IDLE is ignored; the core holds it.
- Reset values: `req_ready` = 1 once out of reset; `resp_valid`, `resp_fault`, `mem_en`, `mem_we` = 0; `mem_be`, `resp_rdata`, `out` = 0.

## Timing
- Accept in cycle T.
- Faulting request: `resp_valid` at T+1.
- Store: memory write at T+1, `resp_valid` at T+2.
- Load: `mem_en` at T+1, `mem_rdata` sampled at T+2, `resp_valid` with data at T+3.
- Back-to-back requests: the next accept is possible in the cycle after RESP.
- `resp_rdata`/`resp_fault` are registered. They hold their values until the next RESP.

## Configuration
- `PEACH_LSU_MMIO_EN` defined:
  - Any access whose word address equals `MMIO_ADDR[31:2]` bypasses memory, with no `mem_en`.
  - Such a store updates `out` from the byte-enabled lane-0 byte, i.e. `mem_wdata[7:0]` when `be[0]`.
  - Such a load returns the word {24'b0, `out`} through normal extraction.
  - Latency is unchanged.
- `PEACH_LSU_MMIO_EN` undefined:
  - No address decode; every access goes to memory.
  - `out` is tied to 8'h00.

## Structure
- `peach_pkg` holds:
  - The funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - The LSU state enum.
  - The opcode defines shared with the core and decoder.
- Sub-module `peach_lsu_align` is combinational. It produces the fault flag, `mem_be` and `mem_wdata` from funct3/addr/wdata, and load extraction from funct3/addr/rdata.
- The FSM and registers stay in `peach_lsu`.

## Test plan
- SW at addr 0x10, data 0xDEADBEEF → at T+1: `mem_en=1`, `mem_we=1`, `be=1111`, `mem_addr=0x4`, `wdata=0xDEADBEEF`; at T+2: `resp_valid=1`, `fault=0`.
- LB at 0x13 with `mem_rdata=0x80FF1234` → `resp_rdata=0xFFFFFF80` at T+3; LBU at 0x13 → 0x00000080; LHU at 0x12 → 0x000080FF.
- SH at 0x06, data 0x0000ABCD → `be=1100`, `mem_wdata=0xABCDABCD`; SB at 0x05, data 0x11 → `be=0010`.
- LW at 0x02 → `resp_fault=1`, `rdata=0` at T+1, `mem_en` never asserted; load funct3=3 → fault.
- Store accepted, `reset` high during ACCESS → `mem_we=0` that cycle, IDLE next cycle, no `resp_valid`.
- With `PEACH_LSU_MMIO_EN`: SB at 0xFFFFFF00, data 0x5A → `out=0x5A` from T+2, no `mem_en`; LBU at 0xFFFFFF00 → `rdata=0x5A`.
